// File: rtl/arm_ctl_pkg.sv
// Shared types and decode helpers for the multicycle ARM control unit.
package arm_ctl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_MULEX  = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_ADC = 3'b100
  } alu_ctl_e;

  // Data-processing cmd field encodings (instr[24:21])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ADC = 4'b0101;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Condition codes (instr[31:28])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Map a data-processing cmd onto the ALU operation; unlisted commands add.
  function automatic alu_ctl_e cmd_to_alu(input logic [3:0] cmd);
    alu_ctl_e res;
    case (cmd)
      CMD_SUB, CMD_CMP: res = ALU_SUB;
      CMD_AND:          res = ALU_AND;
      CMD_ORR:          res = ALU_ORR;
      CMD_ADC:          res = ALU_ADC;
      default:          res = ALU_ADD;
    endcase
    return res;
  endfunction

  // Only arithmetic operations produce meaningful C and V.
  function automatic logic alu_sets_cv(input alu_ctl_e op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_ADC);
  endfunction

endpackage

// File: rtl/cond_unit.sv
// Combinational evaluation of an ARM condition code against stored NZCV flags.
module cond_unit
  import arm_ctl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);

  logic w_n, w_z, w_c, w_v, w_ge;

  assign {w_n, w_z, w_c, w_v} = i_flags;
  assign w_ge = (w_n == w_v);

  // Decode all sixteen condition codes; NV is treated as never-execute.
  always_comb begin
    o_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = w_ge;
      COND_LT: o_cond_ex = ~w_ge;
      COND_GT: o_cond_ex = ~w_z & w_ge;
      COND_LE: o_cond_ex = w_z | ~w_ge;
      COND_AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: instruction sequencing FSM, NZCV flag register,
// condition gating and multiplier stall.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR, PC <= PC+4
// DECODE | read registers, latch condition result
// MEMADR | compute load/store address
// MEMRD  | read data memory at ALU address
// MEMWB  | write loaded data to Rd (or PC)
// MEMWR  | write data memory
// EXECR  | data-processing, register operand
// EXECI  | data-processing, immediate operand
// ALUWB  | write ALU / multiplier result to Rd (or PC)
// BRANCH | PC <= PC+8+offset when condition holds
// MULEX  | multiplier busy for MUL_LATENCY cycles
module multicycle_controller
  import arm_ctl_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter bit ENABLE_MUL  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] cond,
  input  logic [3:0] rd,
  input  logic [3:0] instr74,
  input  logic [3:0] alu_flags,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [2:0] alu_ctl,
  output logic [3:0] mul_ctl,
  output logic       carry,
  output logic       busy_mul
);

  state_e     r_state;
  logic [3:0] r_flags;
  logic       r_cond_ex;
  logic [3:0] r_mul_cnt;

  logic       w_cond_ex;
  logic       w_is_mul;
  logic       w_is_cmp;
  logic       w_rd_pc;
  logic       w_mul_last;
  logic       w_s_bit;
  logic       w_l_bit;
  logic       w_i_bit;
  alu_ctl_e   w_alu_dp;

  // The IR is held for the whole instruction, so decode from it directly.
  assign w_i_bit    = funct[5];
  assign w_s_bit    = funct[0];
  assign w_l_bit    = funct[0];
  assign w_is_mul   = ENABLE_MUL && (op == 2'b00) && (funct[5:4] == 2'b00) && (instr74 == 4'b1001);
  assign w_is_cmp   = (funct[4:1] == CMD_CMP);
  assign w_rd_pc    = (rd == 4'hF);
  assign w_alu_dp   = cmd_to_alu(funct[4:1]);
  assign w_mul_last = (r_mul_cnt == 4'(MUL_LATENCY - 1));

  assign imm_src = op;
  assign reg_src = {(op == 2'b01) && !w_l_bit, (op == 2'b10)};
  assign carry   = r_flags[1];

  cond_unit u_cond (
    .i_cond    (cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  // State sequencing, condition latch, flag commit and multiply cycle count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_flags   <= 4'b0000;
      r_cond_ex <= 1'b0;
      r_mul_cnt <= 4'd0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_cond_ex <= w_cond_ex;
          case (op)
            2'b00: begin
              if (w_is_mul)     r_state <= S_MULEX;
              else if (w_i_bit) r_state <= S_EXECI;
              else              r_state <= S_EXECR;
            end
            2'b01:   r_state <= S_MEMADR;
            2'b10:   r_state <= S_BRANCH;
            default: r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= w_l_bit ? S_MEMRD : S_MEMWR;
        S_MEMRD:  r_state <= S_MEMWB;
        S_EXECR, S_EXECI: begin
          r_state <= S_ALUWB;
          if (w_s_bit && r_cond_ex) begin
            r_flags[3:2] <= alu_flags[3:2];
            if (alu_sets_cv(w_alu_dp)) r_flags[1:0] <= alu_flags[1:0];
          end
        end
        S_MULEX: begin
          if (w_mul_last) begin
            r_state   <= S_ALUWB;
            r_mul_cnt <= 4'd0;
            if (w_s_bit && r_cond_ex) r_flags[3:2] <= alu_flags[3:2];
          end else begin
            r_mul_cnt <= r_mul_cnt + 4'd1;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from the current state; writes gated by the latched condition.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_ctl    = ALU_ADD;
    mul_ctl    = 4'b0000;
    busy_mul   = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_write = r_cond_ex;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = r_cond_ex & ~w_rd_pc;
        pc_write   = r_cond_ex & w_rd_pc;
      end
      S_EXECR: alu_ctl = w_alu_dp;
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu_ctl   = w_alu_dp;
      end
      S_ALUWB: begin
        // CMP only updates flags, so it never writes a destination.
        result_src = w_is_mul ? 2'b11 : 2'b00;
        reg_write  = r_cond_ex & ~w_is_cmp & ~w_rd_pc;
        pc_write   = r_cond_ex & ~w_is_cmp & w_rd_pc;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = r_cond_ex;
      end
      S_MULEX: begin
        busy_mul = 1'b1;
        mul_ctl  = {1'b1, funct[3:1]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller (MUL_LATENCY = 3).
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] op = 2'b00;
   logic [5:0] funct = 6'b000000;
   logic [3:0] cond = 4'b1110;
   logic [3:0] rd = 4'b0000;
   logic [3:0] instr74 = 4'b0000;
   logic [3:0] alu_flags = 4'b0000;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, reg_src;
   logic [2:0] alu_ctl;
   logic [3:0] mul_ctl;
   logic       carry, busy_mul;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.MUL_LATENCY(3), .ENABLE_MUL(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .cond       (cond),
      .rd         (rd),
      .instr74    (instr74),
      .alu_flags  (alu_flags),
      .pc_write   (pc_write),
      .adr_src    (adr_src),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .imm_src    (imm_src),
      .reg_src    (reg_src),
      .alu_ctl    (alu_ctl),
      .mul_ctl    (mul_ctl),
      .carry      (carry),
      .busy_mul   (busy_mul)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic dp(input string tag, input logic [5:0] f, input logic [3:0] c, input logic [3:0] d,
                     input logic [3:0] fl, input logic [2:0] exp_ctl, input logic exp_rw, input logic exp_pw);
      op = 2'b00; funct = f; cond = c; rd = d; instr74 = 4'b0000; alu_flags = fl;
      chk({tag, ".fetch_ir"}, 8'(ir_write), 8'(1));
      step();
      chk({tag, ".dec_pc"}, 8'(pc_write), 8'(0));
      step();
      chk({tag, ".ex_ctl"}, 8'(alu_ctl), 8'(exp_ctl));
      chk({tag, ".ex_srcb"}, 8'(alu_src_b), 8'(f[5] ? 2'b01 : 2'b00));
      chk({tag, ".ex_rw"}, 8'(reg_write), 8'(0));
      step();
      chk({tag, ".wb_rw"}, 8'(reg_write), 8'(exp_rw));
      chk({tag, ".wb_pw"}, 8'(pc_write), 8'(exp_pw));
      chk({tag, ".wb_rsrc"}, 8'(result_src), 8'(2'b00));
      step();
   endtask

   task automatic br(input string tag, input logic [3:0] c, input logic exp_pw);
      op = 2'b10; funct = 6'b100000; cond = c; rd = 4'b0000; instr74 = 4'b0000;
      chk({tag, ".fetch_ir"}, 8'(ir_write), 8'(1));
      step();
      chk({tag, ".dec_regsrc"}, 8'(reg_src), 8'(2'b01));
      step();
      chk({tag, ".br_pw"}, 8'(pc_write), 8'(exp_pw));
      chk({tag, ".br_srcb"}, 8'(alu_src_b), 8'(2'b01));
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      checks++;
      if (pc_write !== 1'b1) begin errors++; $error("FAIL rst.pc_write"); end
      checks++;
      if (ir_write !== 1'b1) begin errors++; $error("FAIL rst.ir_write"); end
      checks++;
      if (alu_src_a !== 2'b01) begin errors++; $error("FAIL rst.alu_src_a"); end
      checks++;
      if (alu_src_b !== 2'b10) begin errors++; $error("FAIL rst.alu_src_b"); end
      checks++;
      if (result_src !== 2'b10) begin errors++; $error("FAIL rst.result_src"); end
      checks++;
      if (mem_write !== 1'b0) begin errors++; $error("FAIL rst.mem_write"); end
      checks++;
      if (reg_write !== 1'b0) begin errors++; $error("FAIL rst.reg_write"); end
      checks++;
      if (carry !== 1'b0) begin errors++; $error("FAIL rst.carry"); end
      checks++;
      if (busy_mul !== 1'b0) begin errors++; $error("FAIL rst.busy_mul"); end
      reset = 1'b1;

      dp("add_imm", 6'b101000, 4'b1110, 4'd1, 4'b0000, 3'b000, 1'b1, 1'b0);
      chk("add_imm.back_fetch", 8'(ir_write), 8'(1));

      op = 2'b01; funct = 6'b011001; cond = 4'b1110; rd = 4'd2;
      step();
      chk("ldr.dec_regsrc", 8'(reg_src), 8'(2'b00));
      step();
      chk("ldr.adr_srcb", 8'(alu_src_b), 8'(2'b01));
      chk("ldr.adr_adrsrc", 8'(adr_src), 8'(0));
      step();
      chk("ldr.rd_adrsrc", 8'(adr_src), 8'(1));
      step();
      chk("ldr.wb_rsrc", 8'(result_src), 8'(2'b01));
      chk("ldr.wb_rw", 8'(reg_write), 8'(1));
      step();
      chk("ldr.back_fetch", 8'(ir_write), 8'(1));

      dp("subs_z", 6'b000101, 4'b1110, 4'd3, 4'b0100, 3'b001, 1'b1, 1'b0);
      br("beq_taken", 4'b0000, 1'b1);
      dp("subs_nz", 6'b000101, 4'b1110, 4'd3, 4'b0000, 3'b001, 1'b1, 1'b0);
      br("beq_not", 4'b0000, 1'b0);

      dp("adds_c", 6'b001001, 4'b1110, 4'd4, 4'b0010, 3'b000, 1'b1, 1'b0);
      chk("adds_c.carry", 8'(carry), 8'(1));
      dp("adc", 6'b001010, 4'b1110, 4'd5, 4'b0000, 3'b100, 1'b1, 1'b0);
      chk("adc.carry", 8'(carry), 8'(1));

      dp("ands", 6'b000001, 4'b1110, 4'd6, 4'b0100, 3'b010, 1'b1, 1'b0);
      chk("ands.carry_kept", 8'(carry), 8'(1));
      br("beq_after_ands", 4'b0000, 1'b1);

      dp("cmp", 6'b010101, 4'b1110, 4'd0, 4'b0000, 3'b001, 1'b0, 1'b0);
      chk("cmp.carry", 8'(carry), 8'(0));

      dp("addeq_skip", 6'b101000, 4'b0000, 4'd1, 4'b0000, 3'b000, 1'b0, 1'b0);

      dp("add_pc", 6'b101000, 4'b1110, 4'hF, 4'b0000, 3'b000, 1'b0, 1'b1);

      op = 2'b00; funct = 6'b001000; cond = 4'b1110; rd = 4'd7; instr74 = 4'b1001; alu_flags = 4'b1111;
      step();
      chk("mul.dec_busy", 8'(busy_mul), 8'(0));
      step();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy_mul !== 1'b1) begin
            errors++;
            $error("FAIL mul.busy%0d: observed %0b", i, busy_mul);
         end
         checks++;
         if (mul_ctl !== 4'b1100) begin
            errors++;
            $error("FAIL mul.ctl%0d: observed %0h", i, mul_ctl);
         end
         step();
      end
      chk("mul.wb_busy", 8'(busy_mul), 8'(0));
      chk("mul.wb_mulctl", 8'(mul_ctl), 8'(4'b0000));
      chk("mul.wb_rsrc", 8'(result_src), 8'(2'b11));
      chk("mul.wb_rw", 8'(reg_write), 8'(1));
      step();
      chk("mul.back_fetch", 8'(ir_write), 8'(1));
      chk("mul.carry", 8'(carry), 8'(0));
      alu_flags = 4'b0000;
      instr74 = 4'b0000;

      op = 2'b11; funct = 6'b000000; rd = 4'd1;
      step();
      chk("undef.dec_rw", 8'(reg_write), 8'(0));
      step();
      chk("undef.back_fetch", 8'(ir_write), 8'(1));

      dp("adds_c2", 6'b001001, 4'b1110, 4'd4, 4'b0010, 3'b000, 1'b1, 1'b0);
      chk("adds_c2.carry", 8'(carry), 8'(1));

      op = 2'b01; funct = 6'b011000; cond = 4'b1110; rd = 4'd5;
      step();
      chk("str.dec_regsrc", 8'(reg_src), 8'(2'b10));
      step();
      step();
      chk("str.wr_memwrite", 8'(mem_write), 8'(1));
      chk("str.wr_adrsrc", 8'(adr_src), 8'(1));
      #2 reset = 1'b0;
      #1;
      chk("str.rst_memwrite", 8'(mem_write), 8'(0));
      chk("str.rst_fetch", 8'(ir_write), 8'(1));
      chk("str.rst_carry", 8'(carry), 8'(0));
      step();
      chk("str.hold_fetch", 8'(ir_write), 8'(1));
      chk("str.hold_memwrite", 8'(mem_write), 8'(0));
      reset = 1'b1;
      step();
      chk("str.after_dec_ir", 8'(ir_write), 8'(0));
      chk("str.after_dec_mw", 8'(mem_write), 8'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
